// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH stages of {valid, ctrl, data} with stall, flush,
// occupancy and a saturating bubble counter. Bubbles always carry a zero control word.
module pipe_stage_reg #(
  parameter int CTRL_W    = 8,
  parameter int DATA_W    = 106,
  parameter int DEPTH     = 1,
  parameter bit FLUSH_ALL = 1'b0
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           In_Valid,
  input  logic [CTRL_W-1:0]              In_Ctrl,
  input  logic [DATA_W-1:0]              In_Data,
  input  logic                           Stall,
  input  logic                           Flush,
  output logic                           Out_Valid,
  output logic [CTRL_W-1:0]              Out_Ctrl,
  output logic [DATA_W-1:0]              Out_Data,
  output logic [$clog2(DEPTH+1)-1:0]     Occupancy,
  output logic [15:0]                    Bubble_Count
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [15:0]       bubble_q, bubble_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (Flush && FLUSH_ALL) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
        ctrl_d[i]  = '0;
        data_d[i]  = '0;
      end
    end else begin
      // Older stages keep draining during a flush even if Stall is also high.
      if (Flush || !Stall) begin
        for (int i = 1; i < DEPTH; i++) begin
          valid_d[i] = valid_q[i-1];
          ctrl_d[i]  = ctrl_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
      if (Flush) begin
        valid_d[0] = 1'b0;
        ctrl_d[0]  = '0;
        data_d[0]  = '0;
      end else if (!Stall) begin
        valid_d[0] = In_Valid;
        ctrl_d[0]  = In_Ctrl & {CTRL_W{In_Valid}};
        data_d[0]  = In_Data;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!Stall && !Flush && !valid_q[DEPTH-1] && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      valid_q  <= '0;
      occ_q    <= '0;
      bubble_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      occ_q    <= occ_d;
      bubble_q <= bubble_d;
    end
  end

  assign Out_Valid    = valid_q[DEPTH-1];
  assign Out_Ctrl     = ctrl_q[DEPTH-1];
  assign Out_Data     = data_q[DEPTH-1];
  assign Occupancy    = occ_q;
  assign Bubble_Count = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 1, 2, 3 drain-flush, 3 full-flush)
// share one stimulus bus; each test resets them and checks the relevant instance.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 106;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          flush;

  logic          v1, v2, v3, v3a;
  logic [CW-1:0] c1, c2, c3, c3a;
  logic [DW-1:0] d1, d2, d3, d3a;
  logic [0:0]    o1;
  logic [1:0]    o2, o3, o3a;
  logic [15:0]   b1, b2, b3, b3a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .FLUSH_ALL(1'b0)) u_d1 (
    .Clk(clk), .Rst(rst_n), .In_Valid(in_valid), .In_Ctrl(in_ctrl), .In_Data(in_data),
    .Stall(stall), .Flush(flush), .Out_Valid(v1), .Out_Ctrl(c1), .Out_Data(d1),
    .Occupancy(o1), .Bubble_Count(b1));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .FLUSH_ALL(1'b0)) u_d2 (
    .Clk(clk), .Rst(rst_n), .In_Valid(in_valid), .In_Ctrl(in_ctrl), .In_Data(in_data),
    .Stall(stall), .Flush(flush), .Out_Valid(v2), .Out_Ctrl(c2), .Out_Data(d2),
    .Occupancy(o2), .Bubble_Count(b2));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .FLUSH_ALL(1'b0)) u_d3 (
    .Clk(clk), .Rst(rst_n), .In_Valid(in_valid), .In_Ctrl(in_ctrl), .In_Data(in_data),
    .Stall(stall), .Flush(flush), .Out_Valid(v3), .Out_Ctrl(c3), .Out_Data(d3),
    .Occupancy(o3), .Bubble_Count(b3));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .FLUSH_ALL(1'b1)) u_d3a (
    .Clk(clk), .Rst(rst_n), .In_Valid(in_valid), .In_Ctrl(in_ctrl), .In_Data(in_data),
    .Stall(stall), .Flush(flush), .Out_Valid(v3a), .Out_Ctrl(c3a), .Out_Data(d3a),
    .Occupancy(o3a), .Bubble_Count(b3a));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0);
    stall = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    #2;

    // 1: reset holds everything at zero even with live inputs
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 106'h123);
    tick();
    tick();
    check("rst_v1", v1, 0);
    check("rst_c1", c1, 0);
    check("rst_d1", d1, 0);
    check("rst_o1", o1, 0);
    check("rst_b1", b1, 0);
    check("rst_c3", c3, 0);
    check("rst_o3", o3, 0);

    // 2: DEPTH=1 plain register, DEPTH=2 one cycle later
    rst_n = 1'b1;
    drive(1'b1, 8'h11, 106'd1);
    tick();
    check("d1_out1", d1, 1);
    check("d1_v1", v1, 1);
    check("d1_c1", c1, 8'h11);
    check("d1_occ", o1, 1);
    drive(1'b1, 8'h12, 106'd2);
    tick();
    check("d1_out2", d1, 2);
    check("d2_out1", d2, 1);
    drive(1'b1, 8'h13, 106'd3);
    tick();
    check("d1_out3", d1, 3);
    check("d2_out2", d2, 2);
    check("d1_bub", b1, 1);
    check("d2_bub", b2, 2);

    // 3: DEPTH=2 latency, then the same with a stall in the middle
    do_reset();
    drive(1'b1, 8'h01, 106'hDEAD_BEEF);
    tick();
    drive(1'b0, 8'h00, '0);
    check("d2_lat_v_early", v2, 0);
    tick();
    check("d2_lat_v", v2, 1);
    check("d2_lat_d", d2, 106'hDEAD_BEEF);
    do_reset();
    drive(1'b1, 8'h01, 106'hDEAD_BEEF);
    tick();
    drive(1'b0, 8'h00, '0);
    stall = 1'b1;
    tick();
    check("d2_stall_v", v2, 0);
    check("d2_stall_occ", o2, 1);
    stall = 1'b0;
    tick();
    check("d2_stall_v_late", v2, 1);
    check("d2_stall_d_late", d2, 106'hDEAD_BEEF);

    // 4: flush+stall on a full DEPTH=3 pipe, drain vs. clear-all
    do_reset();
    drive(1'b1, 8'h01, 106'hA);
    tick();
    drive(1'b1, 8'h02, 106'hB);
    tick();
    drive(1'b1, 8'h03, 106'hC);
    tick();
    check("d3_full_occ", o3, 3);
    check("d3_full_out", d3, 106'hA);
    check("d3a_full_occ", o3a, 3);
    drive(1'b1, 8'h04, 106'hD);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("d3_flush_out", d3, 106'hB);
    check("d3_flush_v", v3, 1);
    check("d3_flush_c", c3, 8'h02);
    check("d3_flush_occ", o3, 2);
    check("d3a_flush_v", v3a, 0);
    check("d3a_flush_c", c3a, 0);
    check("d3a_flush_d", d3a, 0);
    check("d3a_flush_occ", o3a, 0);

    // 5: invalid input never leaks ctrl; bubble counter saturates
    do_reset();
    drive(1'b0, 8'hA5, 106'h5);
    tick();
    tick();
    tick();
    check("inv_c3", c3, 0);
    check("inv_v3", v3, 0);
    check("bub_3", b1, 3);
    stall = 1'b1;
    tick();
    check("bub_stall", b1, 3);
    stall = 1'b0;
    flush = 1'b1;
    tick();
    check("bub_flush", b1, 3);
    flush = 1'b0;
    repeat (65531) tick();
    check("bub_fffe", b1, 16'hFFFE);
    tick();
    check("bub_ffff", b1, 16'hFFFF);
    tick();
    check("bub_hold", b1, 16'hFFFF);

    // 6: reset mid-stream with a full pipe, then DEPTH-cycle latency again
    rst_n = 1'b1;
    drive(1'b1, 8'h21, 106'h1);
    tick();
    drive(1'b1, 8'h22, 106'h2);
    tick();
    drive(1'b1, 8'h23, 106'h3);
    tick();
    check("mid_occ", o3, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_v", v3, 0);
    check("mid_d", d3, 0);
    check("mid_c", c3, 0);
    check("mid_occ0", o3, 0);
    check("mid_bub", b3, 0);
    drive(1'b1, 8'h77, 106'h77);
    tick();
    drive(1'b0, '0, '0);
    tick();
    check("post_v_early", v3, 0);
    tick();
    check("post_v", v3, 1);
    check("post_d", d3, 106'h77);
    check("post_c", c3, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
